emd_sift_sub: RTL and testbench

- Sifting subtract stage of the EMD datapath. Sits directly downstream of the 120-sample delay line.
- Takes the delayed input sample and the upper/lower envelope samples that are time-aligned with it. Computes the envelope mean, then produces the candidate IMF sample h = x - mean with saturation.
- Accumulates |mean| over one frame and flags whether the sifting stop criterion is met.

---
 rtl/emd_sift_sub.sv | 144 ++++++++++++++
 tb/tb_emd_sift_sub.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emd_sift_sub.sv
// Sifting subtract stage: h = x - (upper + lower) / 2 with saturation,
// plus a per-frame sum of |mean| used to decide when sifting can stop.
module emd_sift_sub #(
    parameter int unsigned     W         = 16,
    parameter int unsigned     FRAME_LEN = 1024,
    parameter int unsigned     CNT_W     = 10,
    parameter int unsigned     ACC_W     = 27,
    parameter logic [ACC_W-1:0] THRESH   = ACC_W'(65536)
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                START,
    input  logic                IN_VALID,
    input  logic signed [W-1:0] XD,
    input  logic signed [W-1:0] UPPER,
    input  logic signed [W-1:0] LOWER,
    output logic signed [W-1:0] H,
    output logic                H_VALID,
    output logic [ACC_W-1:0]    MEAN_SUM,
    output logic                FRAME_DONE,
    output logic                SIFT_STOP,
    output logic                BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_EVAL = 2'd2
    } state_t;

    state_t state;

    // Stage 1 registers
    logic                s1_v;
    logic signed [W:0]   s1_sum;
    logic signed [W-1:0] s1_xd;

    // Stage 2 registers
    logic                s2_v;
    logic signed [W+1:0] s2_diff;
    logic [W-1:0]        s2_amean;

    // Frame accumulation
    logic [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]    cnt;

    // Stage 2 / stage 3 combinational terms
    logic signed [W:0]   mean_c;
    logic signed [W+1:0] diff_c;
    logic [W-1:0]        amean_c;
    logic [W-1:0]        h_sat_c;
    logic [ACC_W:0]      acc_sum_c;
    logic [ACC_W-1:0]    acc_nxt_c;

    // Mean (floor of sum/2), difference and magnitude feeding stage 2
    always_comb begin
        mean_c  = s1_sum >>> 1;
        diff_c  = {{2{s1_xd[W-1]}}, s1_xd} - {mean_c[W], mean_c};
        amean_c = mean_c[W] ? W'(-mean_c) : W'(mean_c);
    end

    // Clamp the W+2 bit difference into the W-bit signed output range
    always_comb begin
        h_sat_c = s2_diff[W-1:0];
        if ((s2_diff[W+1] != s2_diff[W]) || (s2_diff[W] != s2_diff[W-1])) begin
            h_sat_c = s2_diff[W+1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

    // Saturating add of the current |mean| into the frame accumulator
    always_comb begin
        acc_sum_c = {1'b0, acc} + (ACC_W+1)'(s2_amean);
        acc_nxt_c = acc_sum_c[ACC_W] ? {ACC_W{1'b1}} : acc_sum_c[ACC_W-1:0];
    end

    // Three-stage datapath pipeline; runs regardless of FSM state
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_v     <= 1'b0;
            s1_sum   <= '0;
            s1_xd    <= '0;
            s2_v     <= 1'b0;
            s2_diff  <= '0;
            s2_amean <= '0;
            H        <= '0;
            H_VALID  <= 1'b0;
        end else begin
            s1_v     <= IN_VALID;
            s1_sum   <= {UPPER[W-1], UPPER} + {LOWER[W-1], LOWER};
            s1_xd    <= XD;
            s2_v     <= s1_v;
            s2_diff  <= diff_c;
            s2_amean <= amean_c;
            H        <= h_sat_c;
            H_VALID  <= s2_v;
        end
    end

    // Frame control: accumulate |mean| over FRAME_LEN samples, then evaluate once
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            acc        <= '0;
            cnt        <= '0;
            MEAN_SUM   <= '0;
            SIFT_STOP  <= 1'b0;
            FRAME_DONE <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            FRAME_DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        state <= ST_RUN;
                        acc   <= '0;
                        cnt   <= '0;
                        BUSY  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (s2_v) begin
                        acc <= acc_nxt_c;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(FRAME_LEN - 1)) begin
                            state      <= ST_EVAL;
                            FRAME_DONE <= 1'b1;
                        end
                    end
                end
                ST_EVAL: begin
                    MEAN_SUM  <= acc;
                    SIFT_STOP <= (acc <= THRESH);
                    state     <= ST_IDLE;
                    BUSY      <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_emd_sift_sub.sv
// Self-checking bench for emd_sift_sub (FRAME_LEN reduced to 4).
module tb_emd_sift_sub;

    logic               CLK;
    logic               RST_N;
    logic               START;
    logic               IN_VALID;
    logic signed [15:0] XD;
    logic signed [15:0] UPPER;
    logic signed [15:0] LOWER;
    logic signed [15:0] H;
    logic               H_VALID;
    logic [26:0]        MEAN_SUM;
    logic               FRAME_DONE;
    logic               SIFT_STOP;
    logic               BUSY;

    int npass  = 0;
    int ntotal = 0;

    // FRAME_DONE observation state
    int   fd_count = 0;
    bit   fd_prev  = 0;
    logic busy_at_fd;
    logic busy_after_fd;

    // Frame stimulus
    int fx[4];
    int fu[4];
    int fl[4];

    emd_sift_sub #(
        .W(16), .FRAME_LEN(4), .CNT_W(10), .ACC_W(27), .THRESH(27'd65536)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .IN_VALID(IN_VALID),
        .XD(XD), .UPPER(UPPER), .LOWER(LOWER), .H(H), .H_VALID(H_VALID),
        .MEAN_SUM(MEAN_SUM), .FRAME_DONE(FRAME_DONE), .SIFT_STOP(SIFT_STOP),
        .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, passed %0d of %0d", npass, ntotal);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int mean_of(int u, int l);
        int s;
        s = u + l;
        return (s - (((s % 2) + 2) % 2)) / 2;
    endfunction

    function automatic int exp_h(int x, int u, int l);
        int d;
        d = x - mean_of(u, l);
        if (d > 32767)  d = 32767;
        if (d < -32768) d = -32768;
        return d;
    endfunction

    function automatic longint frame_sum();
        longint s;
        int m;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            m = mean_of(fu[i], fl[i]);
            s += (m < 0) ? -m : m;
        end
        if (s > 64'd134217727) s = 64'd134217727;
        return s;
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic tickm();
        tick();
        if (fd_prev) busy_after_fd = BUSY;
        fd_prev = (FRAME_DONE === 1'b1);
        if (fd_prev) begin
            fd_count++;
            busy_at_fd = BUSY;
        end
    endtask

    task automatic flush();
        IN_VALID = 1'b0;
        START    = 1'b0;
        repeat (4) tickm();
    endtask

    task automatic run_frame(input bit mid_start);
        fd_count = 0;
        fd_prev  = 0;
        START = 1'b1;
        tickm();
        START = 1'b0;
        for (int i = 0; i < 4; i++) begin
            IN_VALID = 1'b1;
            XD    = 16'(fx[i]);
            UPPER = 16'(fu[i]);
            LOWER = 16'(fl[i]);
            START = (mid_start && i == 1);
            tickm();
            IN_VALID = 1'b0;
            START    = 1'b0;
            repeat ($urandom_range(0, 2)) tickm();
        end
        repeat (12) tickm();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        START = 1'b0;
        RST_N = 1'b0;
        for (int i = 0; i < 3; i++) begin
            IN_VALID = 1'b1;
            XD = 16'($urandom); UPPER = 16'($urandom); LOWER = 16'($urandom);
            tick();
            ntotal++;
            if ({H, H_VALID, MEAN_SUM, FRAME_DONE, SIFT_STOP, BUSY} !== '0) begin
                $display("FAIL reset_outputs: H=%0d HV=%b MS=%0d FD=%b SS=%b BUSY=%b, required all 0",
                         H, H_VALID, MEAN_SUM, FRAME_DONE, SIFT_STOP, BUSY);
            end else npass++;
        end
        RST_N = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            XD = 16'($urandom); UPPER = 16'($urandom); LOWER = 16'($urandom);
            tick();
            ntotal++;
            if (H_VALID !== (c == 3)) begin
                $display("FAIL reset_latency c%0d: H_VALID=%b required %b", c, H_VALID, (c == 3));
            end else npass++;
        end
        flush();
    endtask

    task automatic test_directed_h();
        int vx[4] = '{1000, 0, 32767, -32768};
        int vu[4] = '{300, 3, -32768, 32767};
        int vl[4] = '{100, -4, -32768, 32767};
        int ve[4] = '{800, 1, 32767, -32768};
        for (int i = 0; i < 4; i++) begin
            IN_VALID = 1'b1;
            XD = 16'(vx[i]); UPPER = 16'(vu[i]); LOWER = 16'(vl[i]);
            tick();
            IN_VALID = 1'b0;
            tick();
            tick();
            ntotal++;
            if (H_VALID !== 1'b1 || H !== 16'(ve[i])) begin
                $display("FAIL directed_h%0d: H=%0d HV=%b required H=%0d HV=1", i, H, H_VALID, ve[i]);
            end else npass++;
            tick();
            ntotal++;
            if (H_VALID !== 1'b0) begin
                $display("FAIL directed_pulse%0d: H_VALID=%b required 0", i, H_VALID);
            end else npass++;
        end
        flush();
    endtask

    task automatic test_random_h();
        int qv[$];
        int qh[$];
        int ev, eh, x, u, l;
        qv.push_back(0); qh.push_back(0);
        qv.push_back(0); qh.push_back(0);
        for (int n = 0; n < 200; n++) begin
            IN_VALID = ($urandom_range(0, 3) != 0);
            x = int'($signed(16'($urandom)));
            u = int'($signed(16'($urandom)));
            l = int'($signed(16'($urandom)));
            XD = 16'(x); UPPER = 16'(u); LOWER = 16'(l);
            qv.push_back(IN_VALID ? 1 : 0);
            qh.push_back(exp_h(x, u, l));
            tick();
            ev = qv.pop_front();
            eh = qh.pop_front();
            ntotal++;
            if (H_VALID !== (ev == 1) || (ev == 1 && H !== 16'(eh))) begin
                $display("FAIL random_h n%0d: H=%0d HV=%b required H=%0d HV=%0d", n, H, H_VALID, eh, ev);
            end else npass++;
        end
        flush();
    endtask

    task automatic check_frame(input string name);
        longint es;
        es = frame_sum();
        ntotal++;
        if (fd_count !== 1) begin
            $display("FAIL %s_done_count: got %0d required 1", name, fd_count);
        end else npass++;
        ntotal++;
        if (MEAN_SUM !== 27'(es)) begin
            $display("FAIL %s_mean_sum: got %0d required %0d", name, MEAN_SUM, es);
        end else npass++;
        ntotal++;
        if (SIFT_STOP !== (es <= 65536)) begin
            $display("FAIL %s_sift_stop: got %b required %b", name, SIFT_STOP, (es <= 65536));
        end else npass++;
        ntotal++;
        if (busy_at_fd !== 1'b1 || busy_after_fd !== 1'b0) begin
            $display("FAIL %s_busy: at_done=%b after=%b required 1 then 0", name, busy_at_fd, busy_after_fd);
        end else npass++;
    endtask

    task automatic test_frame_small();
        for (int i = 0; i < 4; i++) begin
            fx[i] = int'($urandom_range(0, 500)); fu[i] = 10; fl[i] = -2;
        end
        run_frame(1'b0);
        check_frame("frame_small");
        ntotal++;
        if (MEAN_SUM !== 27'd16 || SIFT_STOP !== 1'b1) begin
            $display("FAIL frame_small_const: MEAN_SUM=%0d SIFT_STOP=%b required 16 and 1", MEAN_SUM, SIFT_STOP);
        end else npass++;
    endtask

    task automatic test_frame_large_mid_start();
        for (int i = 0; i < 4; i++) begin
            fx[i] = 0; fu[i] = 30000; fl[i] = 30000;
        end
        run_frame(1'b1);
        check_frame("frame_large");
        ntotal++;
        if (MEAN_SUM !== 27'd120000 || SIFT_STOP !== 1'b0) begin
            $display("FAIL frame_large_const: MEAN_SUM=%0d SIFT_STOP=%b required 120000 and 0", MEAN_SUM, SIFT_STOP);
        end else npass++;
    endtask

    task automatic test_frame_random();
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 4; i++) begin
                fx[i] = int'($signed(16'($urandom)));
                fu[i] = int'($signed(16'($urandom)));
                fl[i] = (k % 2 == 0) ? int'($signed(16'($urandom)))
                                     : int'($urandom_range(0, 400)) - 200 - fu[i] / 2;
            end
            run_frame(k == 3);
            check_frame("frame_random");
        end
    endtask

    task automatic test_reset_mid_frame();
        longint es;
        for (int i = 0; i < 4; i++) begin
            fx[i] = 0; fu[i] = 10; fl[i] = -2;
        end
        run_frame(1'b0);
        fd_count = 0;
        START = 1'b1;
        tickm();
        START = 1'b0;
        for (int i = 0; i < 2; i++) begin
            IN_VALID = 1'b1; XD = 16'd5; UPPER = 16'd20000; LOWER = 16'd20000;
            tickm();
        end
        IN_VALID = 1'b0;
        repeat (4) tickm();
        RST_N = 1'b0;
        #1;
        ntotal++;
        if (BUSY !== 1'b0 || MEAN_SUM !== '0 || SIFT_STOP !== 1'b0 || FRAME_DONE !== 1'b0) begin
            $display("FAIL midreset_clear: BUSY=%b MEAN_SUM=%0d SIFT_STOP=%b FD=%b required all 0",
                     BUSY, MEAN_SUM, SIFT_STOP, FRAME_DONE);
        end else npass++;
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) tickm();
        ntotal++;
        if (fd_count !== 0) begin
            $display("FAIL midreset_no_done: FRAME_DONE pulses=%0d required 0", fd_count);
        end else npass++;
        for (int i = 0; i < 4; i++) begin
            fx[i] = i; fu[i] = 100 * (i + 1); fl[i] = -7;
        end
        START = 1'b1;
        tickm();
        START = 1'b0;
        for (int i = 0; i < 3; i++) begin
            IN_VALID = 1'b1; XD = 16'(fx[i]); UPPER = 16'(fu[i]); LOWER = 16'(fl[i]);
            tickm();
        end
        IN_VALID = 1'b0;
        repeat (8) tickm();
        ntotal++;
        if (fd_count !== 0 || BUSY !== 1'b1) begin
            $display("FAIL midreset_partial: pulses=%0d BUSY=%b required 0 and 1", fd_count, BUSY);
        end else npass++;
        IN_VALID = 1'b1; XD = 16'(fx[3]); UPPER = 16'(fu[3]); LOWER = 16'(fl[3]);
        tickm();
        IN_VALID = 1'b0;
        repeat (12) tickm();
        es = frame_sum();
        ntotal++;
        if (fd_count !== 1 || MEAN_SUM !== 27'(es) || BUSY !== 1'b0) begin
            $display("FAIL midreset_refill: pulses=%0d MEAN_SUM=%0d BUSY=%b required 1, %0d, 0",
                     fd_count, MEAN_SUM, BUSY, es);
        end else npass++;
    endtask

    initial begin
        RST_N    = 1'b1;
        START    = 1'b0;
        IN_VALID = 1'b0;
        XD = '0; UPPER = '0; LOWER = '0;
        #3;
        test_reset();
        test_directed_h();
        test_random_h();
        test_frame_small();
        test_frame_large_mid_start();
        test_frame_random();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
